// File: rtl/bus_arbiter_if.sv
// Bus bundle for bus_arbiter: two master ports, one slave port, status.
// The slave modport is the arbiter's view; master is the environment's.
interface bus_arbiter_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      m0_address, m1_address;
    logic             m0_read, m1_read;
    logic             m0_write, m1_write;
    logic [3:0]       m0_byteenable, m1_byteenable;
    logic [31:0]      m0_writedata, m1_writedata;
    logic [31:0]      m0_readdata, m1_readdata;
    logic             m0_waitrequest, m1_waitrequest;
    logic [31:0]      address;
    logic             read, write;
    logic [3:0]       byteenable;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic             waitrequest;
    logic [1:0]       owner;
    logic [CNT_W-1:0] m0_xfers, m1_xfers;

    modport slave (
        input  m0_address, m1_address, m0_read, m1_read,
        input  m0_write, m1_write, m0_byteenable, m1_byteenable,
        input  m0_writedata, m1_writedata, readdata, waitrequest,
        output m0_readdata, m1_readdata, m0_waitrequest, m1_waitrequest,
        output address, read, write, byteenable, writedata,
        output owner, m0_xfers, m1_xfers
    );

    modport master (
        output m0_address, m1_address, m0_read, m1_read,
        output m0_write, m1_write, m0_byteenable, m1_byteenable,
        output m0_writedata, m1_writedata, readdata, waitrequest,
        input  m0_readdata, m1_readdata, m0_waitrequest, m1_waitrequest,
        input  address, read, write, byteenable, writedata,
        input  owner, m0_xfers, m1_xfers
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master / one-slave Avalon-style bus arbiter with transfer counters.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is m0 priority.
module bus_arbiter #(
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] m0_xfers_q, m0_xfers_d;
    logic [CNT_W-1:0] m1_xfers_q, m1_xfers_d;
    logic             req0, req1;

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            m0_xfers_q <= '0;
            m1_xfers_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            m0_xfers_q <= m0_xfers_d;
            m1_xfers_q <= m1_xfers_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        last_d             = last_q;
        m0_xfers_d         = m0_xfers_q;
        m1_xfers_d         = m1_xfers_q;
        bus.address        = '0;
        bus.read           = 1'b0;
        bus.write          = 1'b0;
        bus.byteenable     = '0;
        bus.writedata      = '0;
        bus.m0_waitrequest = 1'b1;
        bus.m1_waitrequest = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    // last_q=1 means m1 went last, so m0 is due
                    state_d = last_q ? GNT0 : GNT1;
`else
                    state_d = GNT0;
`endif
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                bus.address        = bus.m0_address;
                bus.read           = bus.m0_read;
                bus.write          = bus.m0_write;
                bus.byteenable     = bus.m0_byteenable;
                bus.writedata      = bus.m0_writedata;
                bus.m0_waitrequest = bus.waitrequest;
                if (!req0) begin
                    state_d = IDLE;
                end else if (!bus.waitrequest) begin
                    state_d    = IDLE;
                    last_d     = 1'b0;
                    m0_xfers_d = m0_xfers_q + CNT_W'(1);
                end
            end
            GNT1: begin
                bus.address        = bus.m1_address;
                bus.read           = bus.m1_read;
                bus.write          = bus.m1_write;
                bus.byteenable     = bus.m1_byteenable;
                bus.writedata      = bus.m1_writedata;
                bus.m1_waitrequest = bus.waitrequest;
                if (!req1) begin
                    state_d = IDLE;
                end else if (!bus.waitrequest) begin
                    state_d    = IDLE;
                    last_d     = 1'b1;
                    m1_xfers_d = m1_xfers_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m0_readdata = bus.readdata;
    assign bus.m1_readdata = bus.readdata;
    assign bus.owner       = state_q;
    assign bus.m0_xfers    = m0_xfers_q;
    assign bus.m1_xfers    = m1_xfers_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (narrow counters for wrap).
module tb_bus_arbiter;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bus_arbiter_if #(.CNT_W(CW)) bus ();

    bus_arbiter #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        #1;
        check({tag, " owner"}, 32'(bus.owner), 32'h0);
        check({tag, " rd"}, 32'(bus.read), 32'h0);
        check({tag, " wr"}, 32'(bus.write), 32'h0);
        check({tag, " w0"}, 32'(bus.m0_waitrequest), 32'h1);
        check({tag, " w1"}, 32'(bus.m1_waitrequest), 32'h1);
        check({tag, " addr"}, bus.address, 32'h0);
    endtask

    logic [1:0] exp_own;

    initial begin
        reset = 1'b1;
        bus.m0_address = '0; bus.m1_address = '0;
        bus.m0_read = 0; bus.m1_read = 0;
        bus.m0_write = 0; bus.m1_write = 0;
        bus.m0_byteenable = '0; bus.m1_byteenable = '0;
        bus.m0_writedata = '0; bus.m1_writedata = '0;
        bus.readdata = '0; bus.waitrequest = 1'b0;
        tick(); tick();
        chk_idle("reset");
        check("reset x0", 32'(bus.m0_xfers), 32'h0);
        check("reset x1", 32'(bus.m1_xfers), 32'h0);
        reset = 1'b0;

        // single m0 read
        bus.m0_read = 1; bus.m0_address = 32'h10;
        bus.m0_byteenable = 4'hF; bus.readdata = 32'hDEADBEEF;
        #1 check("rd0 pre owner", 32'(bus.owner), 32'h0);
        tick();
        #1;
        check("rd0 owner", 32'(bus.owner), 32'h1);
        check("rd0 w0", 32'(bus.m0_waitrequest), 32'h0);
        check("rd0 w1", 32'(bus.m1_waitrequest), 32'h1);
        check("rd0 data", bus.m0_readdata, 32'hDEADBEEF);
        check("rd0 addr", bus.address, 32'h10);
        check("rd0 read", 32'(bus.read), 32'h1);
        tick();
        bus.m0_read = 0;
        chk_idle("rd0 done");
        check("rd0 x0", 32'(bus.m0_xfers), 32'h1);

        // m1 write with 3 slave wait states
        bus.m1_write = 1; bus.m1_writedata = 32'h12345678;
        bus.m1_byteenable = 4'b0011; bus.m1_address = 32'h40;
        bus.waitrequest = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.waitrequest = (i < 3);
            #1;
            check("wr1 owner", 32'(bus.owner), 32'h2);
            check("wr1 w1", 32'(bus.m1_waitrequest), (i < 3) ? 32'h1 : 32'h0);
            check("wr1 w0", 32'(bus.m0_waitrequest), 32'h1);
            check("wr1 write", 32'(bus.write), 32'h1);
            check("wr1 wd", bus.writedata, 32'h12345678);
            check("wr1 be", 32'(bus.byteenable), 32'h3);
            check("wr1 x1 mid", 32'(bus.m1_xfers), 32'h0);
            tick();
        end
        bus.m1_write = 0;
        chk_idle("wr1 done");
        check("wr1 x1", 32'(bus.m1_xfers), 32'h1);

        // contention, zero-wait slave, 16 cycles
        bus.waitrequest = 0;
        bus.m1_read = 1;
        for (int c = 0; c < 16; c++) begin
`ifdef ARB_ROUND_ROBIN_EN
            bus.m0_read = 1;
            exp_own = (c % 2 == 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10);
`else
            bus.m0_read = (c < 8);
            exp_own = (c % 2 == 0) ? 2'b00 : ((c < 8) ? 2'b01 : 2'b10);
`endif
            #1 check($sformatf("cont owner c%0d", c), 32'(bus.owner), 32'(exp_own));
            tick();
        end
        bus.m0_read = 0; bus.m1_read = 0;
        chk_idle("cont done");
        check("cont x0", 32'(bus.m0_xfers), 32'h5);
        check("cont x1", 32'(bus.m1_xfers), 32'h5);

        // non-owner stall while m1 holds the bus
        bus.m1_read = 1; bus.m1_address = 32'hA0;
        bus.m0_address = 32'h50; bus.waitrequest = 1;
        tick();
        bus.m0_read = 1;
        for (int i = 0; i < 3; i++) begin
            bus.waitrequest = (i < 2);
            #1;
            check("stall owner", 32'(bus.owner), 32'h2);
            check("stall w0", 32'(bus.m0_waitrequest), 32'h1);
            check("stall addr", bus.address, 32'hA0);
            tick();
        end
        bus.m1_read = 0;
        #1 check("stall idle", 32'(bus.owner), 32'h0);
        check("stall x1", 32'(bus.m1_xfers), 32'h6);
        bus.waitrequest = 1;
        tick();
        #1 check("stall gnt0", 32'(bus.owner), 32'h1);
        check("stall addr0", bus.address, 32'h50);

        // abandon: m0 drops read while stalled
        tick();
        #1 check("abn owner", 32'(bus.owner), 32'h1);
        bus.m0_read = 0;
        #1 check("abn read", 32'(bus.read), 32'h0);
        tick();
        chk_idle("abn idle");
        check("abn x0", 32'(bus.m0_xfers), 32'h5);

        // reset during GNT1 with slave stalled
        bus.m1_write = 1;
        tick();
        #1 check("rst gnt1", 32'(bus.owner), 32'h2);
        reset = 1;
        tick();
        chk_idle("rst mid");
        check("rst x0", 32'(bus.m0_xfers), 32'h0);
        check("rst x1", 32'(bus.m1_xfers), 32'h0);
        reset = 0;
        bus.m1_write = 0;
        bus.waitrequest = 0;
        tick();

        // counter wrap: 16 m0 transfers on a 4-bit counter
        bus.m0_read = 1;
        for (int t = 0; t < 16; t++) begin
            tick();
            tick();
            if (t == 14)
                check("wrap x0 max", 32'(bus.m0_xfers), 32'hF);
        end
        bus.m0_read = 0;
        #1 check("wrap x0", 32'(bus.m0_xfers), 32'h0);
        check("wrap owner", 32'(bus.owner), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the CPU's Avalon-style memory bus (address/read/write/waitrequest/byteenable/readdata/writedata). It sits between `mips_cpu_bus` (master 0) and a second master (master 1, such as a memory loader or DMA engine) on one side, and a single `bus_memory` slave on the other. Each granted transfer runs to completion under slave waitrequest before the next arbitration.

## Interface
Parameters:
- `CNT_W`, default 16: width of the per-master completed-transfer counters.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `m0_address`, `m1_address`  input  32  master byte address
- `m0_read`, `m1_read`  input  1  read request
- `m0_write`, `m1_write`  input  1  write request
- `m0_byteenable`, `m1_byteenable`  input  4  byte lanes
- `m0_writedata`, `m1_writedata`  input  32  write data
- `m0_readdata`, `m1_readdata`  output  32  read data from the slave
- `m0_waitrequest`, `m1_waitrequest`  output  1  stall to the master
- `address`  output  32  to slave
- `read`, `write`  output  1  to slave
- `byteenable`  output  4  to slave
- `writedata`  output  32  to slave
- `readdata`  input  32  from slave
- `waitrequest`  input  1  from slave
- `owner`  output  2  one-hot current grant: 01 = m0, 10 = m1, 00 = idle
- `m0_xfers`, `m1_xfers`  output  CNT_W  completed transfers per master; wraps at 2^CNT_W

## Operation
- Request: `mX_req = mX_read | mX_write`.
- States:
  - IDLE: no slave access; both master waitrequests are 1; slave address/byteenable/writedata/read/write are all 0.
  - GNT0 / GNT1: the owner's address/read/write/byteenable/writedata pass combinationally to the slave. `owner_waitrequest = waitrequest`; the other master's waitrequest is 1. Slave readdata goes to both `mX_readdata`; only the owner's value is meaningful.
- From IDLE:
  - Only m0 requesting -> GNT0. Only m1 requesting -> GNT1.
  - Both requesting: resolved by the policy in Configuration.
  - Neither requesting: stay in IDLE.
- Completion: in GNTx with `mX_req=1` and slave `waitrequest=0`:
  - The transfer completes that cycle.
  - `mX_xfers` increments.
  - `last` is set to x.
  - The next state is IDLE.
- Abandon: in GNTx with `mX_req=0` (a protocol violation), the next state is IDLE. No counter increments and `last` is unchanged.
- Read and write both asserted are forwarded unchanged; the slave defines the result.
- Master request signals are sampled only in IDLE; there is no pre-emption.

## Timing
- Reset values: state IDLE; `owner`=00; `read`=`write`=0; `address`=`byteenable`=`writedata`=0; `m0_waitrequest`=`m1_waitrequest`=1; `m0_xfers`=`m1_xfers`=0; `last`=1, so m0 wins the first tie.
- Grant latency: a request first seen in IDLE at edge N is granted at edge N+1. The slave sees the access in the cycle after N+1.
- Zero-wait slave: a transfer takes 2 cycles (1 arbitration + 1 access). Each slave wait cycle adds 1 cycle.
- Back-to-back requests from one master: 2 cycles minimum per transfer, because of the mandatory IDLE cycle.
- Reset during GNTx: returns to IDLE next edge with outputs at reset values. The in-flight transfer is dropped and not counted.
- Counter wrap: all-ones + 1 -> 0, with no flag.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie in IDLE, grant the master that is not `last`. This alternates m0/m1 under continuous contention.
- Not defined: fixed priority; m0 always wins a tie. `last` is still maintained but has no effect.
- All other behaviour is identical in both builds.

## Test plan
- Single m0 read: m0_read=1, address=0x00000010, slave waitrequest=0, readdata=0xDEADBEEF.
  - Expect `owner`=01 one cycle after the request.
  - Expect m0_waitrequest=0 and m0_readdata=0xDEADBEEF in that cycle.
  - Expect m0_xfers=1 and IDLE next.
- Slave wait states: m1 writes 0x12345678 with byteenable 4'b0011 while the slave holds waitrequest for 3 cycles.
  - m1_waitrequest tracks the slave.
  - write/writedata/byteenable stay stable for 4 access cycles.
  - m1_xfers=1 at the end.
- Contention: m0 and m1 request continuously for 4 transfers each, zero-wait slave.
  - With `ARB_ROUND_ROBIN_EN`: grant order m0,m1,m0,m1,... and final counts 4/4 after 16 cycles.
  - Without it: all m0 grants first, m1 granted only after m0 deasserts.
- Non-owner stall: while GNT1, m0 asserts read.
  - m0_waitrequest=1 and slave address=m1_address throughout.
  - m0 is granted in the cycle after the IDLE that follows.
- Abandon: GNT0 with waitrequest=1, then m0 drops read.
  - Expect IDLE next cycle, m0_xfers unchanged, slave read=0.
- Reset mid-transfer: assert reset during GNT1 with slave waitrequest=1.
  - The next edge gives owner=00, read=write=0, both waitrequests=1, counters=0.
